ahblite_slave_mux: RTL and testbench
====================================

// Module: ahblite_slave_mux
// PURPOSE
//  Return path of the AHB-Lite bus: the counterpart of the address decoder. The decoder drives
//  Pn_HSEL in the address phase. This block registers that selection into the data phase and
//  muxes the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master.
//  It contains a default slave that gives the two-cycle ERROR response to any active transfer
//  to an unmapped or disabled region. Its HREADY output is the system-wide HREADY.
// PARAMETERS
//  Port0_en  1  RAMCODE port present; 0 = treat as unmapped
//  Port1_en  1  RAMDATA port present
//  Port2_en  1  LCD port present
//  Port3_en  1  UART port present
//  Port4_en  1  LED port present
//  Port5_en  1  Buzzer port present
// PORTS
//  HCLK          in   1   bus clock
//  HRESET        in   1   reset, synchronous, active-high
//  HTRANS        in   2   master transfer type (address phase)
//  P0..P5_HSEL   in   1   address-phase selects from the decoder (one port each)
//  P0..P5_HRDATA in   32  slave read data (one port each)
//  P0..P5_HREADYOUT in 1  slave ready (one port each)
//  P0..P5_HRESP  in   1   slave response, 0=OKAY 1=ERROR (one port each)
//  HRDATA        out  32  read data to master
//  HREADY        out  1   system HREADY, fanned out to master and all slaves
//  HRESP         out  1   response to master
// BEHAVIOUR
//  - Reset (HRESET=1 at a HCLK edge): sel_q=6'b0, default-slave state=DS_IDLE.
//    Outputs therefore read HREADY=1, HRESP=0, HRDATA=32'h0 from the next cycle on.
//  - sel_q[5:0] holds the data-phase select. It loads {P5_HSEL..P0_HSEL} & {Port5_en..Port0_en}
//    only on edges where HREADY=1, and holds while HREADY=0 (slave wait states).
//  - Output mux is combinational from sel_q. The lowest set index wins, so overlapping
//    selects resolve to the lowest port. For the winning port k:
//    HRDATA=Pk_HRDATA, HREADY=Pk_HREADYOUT, HRESP=Pk_HRESP.
//  - sel_q==0 means the default slave owns the data phase:
//    HRDATA=32'h0, and HREADY/HRESP come from the default-slave FSM.
//  - Default-slave FSM: DS_IDLE, DS_ERR1, DS_ERR2. Moore outputs:
//      DS_IDLE  HREADY=1 HRESP=0
//      DS_ERR1  HREADY=0 HRESP=1
//      DS_ERR2  HREADY=1 HRESP=1
//  - Define unmapped = no enabled HSEL asserted.
//  - Transitions, evaluated at each edge:
//      DS_IDLE -> DS_ERR1 : HREADY=1, HTRANS[1]=1 (NONSEQ/SEQ) and unmapped
//      DS_ERR1 -> DS_ERR2 : unconditional
//      DS_ERR2 -> DS_ERR1 : HTRANS[1]=1 and unmapped (back-to-back error)
//      DS_ERR2 -> DS_IDLE : otherwise
//    The FSM stays in DS_IDLE whenever a mapped port owns the data phase.
//  - IDLE/BUSY (HTRANS[1]=0) to an unmapped address: zero-wait OKAY, sel_q=0, FSM stays DS_IDLE.
//  - Latency: select to data-phase mux is exactly 1 HCLK, which gives AHB-Lite pipelining.
//    A mapped zero-wait slave adds no cycles. An error costs exactly 2 data-phase cycles.
//  - The master may change HTRANS to IDLE during DS_ERR1. The block samples the address only
//    on the DS_ERR2 edge (HREADY=1), so a cancelled transfer is never selected.
//  - Reset in DS_ERR1 or DS_ERR2 aborts the error and returns to DS_IDLE with HREADY=1 next cycle.
//  - No combinational path from any HREADY input to the sel_q enable other than through HREADY.
//    Pn_HREADYOUT -> HREADY is combinational by design and must not loop back combinationally.
// STRUCTURE
//  - Shared header ahblite_defs.vh holds:
//    HTRANS_IDLE/BUSY/NONSEQ/SEQ (2'b00/01/10/11), HRESP_OKAY/ERROR (1'b0/1'b1),
//    DS_IDLE/DS_ERR1/DS_ERR2 encodings, and the port count (6).
//  - One sub-module, ahblite_default_slave: inputs HCLK, HRESET, HREADY, HTRANS, unmapped;
//    outputs HREADYOUT, HRESP.
//  - sel_q register and priority mux live in the top level.
// TESTING
//  1. Reset: hold HRESET=1 for 2 cycles, release -> HREADY=1, HRESP=0, HRDATA=0.
//  2. NONSEQ read, P1_HSEL=1, P1_HRDATA=32'hA5A5_0001, P1_HREADYOUT=1
//     -> next cycle HRDATA=32'hA5A5_0001, HRESP=0.
//  3. P3_HSEL with P3_HREADYOUT=0 for 3 cycles, with P4_HSEL presented meanwhile
//     -> HREADY=0 for 3 cycles, sel_q stays on port 3, then port 4 data follows.
//  4. NONSEQ to 32'h5000_0000 (no HSEL) -> DS_ERR1 (HREADY=0, HRESP=1), then DS_ERR2
//     (HREADY=1, HRESP=1), then DS_IDLE. Back-to-back unmapped NONSEQ gives ERR1,ERR2,ERR1,ERR2.
//  5. Port2_en=0 build, NONSEQ with P2_HSEL=1 -> ERROR sequence, LCD data never muxed.
//     IDLE to an unmapped address -> zero-wait OKAY.
//  6. HRESET asserted during DS_ERR1 -> next cycle HREADY=1, HRESP=0, sel_q=0.

Source files
------------

// File: rtl/ahblite_slave_mux_pkg.sv
// Shared constants and helpers for the AHB-Lite return-path mux: transfer
// and response encodings, default-slave state codes and the port count.
package ahblite_slave_mux_pkg;

    localparam int NUM_PORTS = 6;
    localparam int HDATA_W   = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] DS_IDLE = 2'b00;
    localparam logic [1:0] DS_ERR1 = 2'b01;
    localparam logic [1:0] DS_ERR2 = 2'b10;

    // Isolate the lowest set bit so overlapping selects resolve to the lowest port.
    function automatic logic [NUM_PORTS-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
        return v & (~v + NUM_PORTS'(1));
    endfunction

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// Bus bundle between the decoder/slaves and the return-path mux.
// The slave modport is the mux view; the master modport drives it.
interface ahblite_slave_mux_if;
    import ahblite_slave_mux_pkg::*;

    logic [1:0]                          htrans;        // address-phase transfer type
    logic [NUM_PORTS-1:0]                hsel;          // address-phase selects, bit k = port k
    logic [NUM_PORTS-1:0][HDATA_W-1:0]   slv_hrdata;    // per-slave read data
    logic [NUM_PORTS-1:0]                slv_hreadyout; // per-slave ready
    logic [NUM_PORTS-1:0]                slv_hresp;     // per-slave response
    logic [HDATA_W-1:0]                  hrdata;        // muxed read data to master
    logic                                hready;        // system HREADY
    logic                                hresp;         // muxed response

    modport slave (
        input  htrans, hsel, slv_hrdata, slv_hreadyout, slv_hresp,
        output hrdata, hready, hresp
    );

    modport master (
        output htrans, hsel, slv_hrdata, slv_hreadyout, slv_hresp,
        input  hrdata, hready, hresp
    );

endinterface

// File: rtl/ahblite_slave_mux_default_slave.sv
// Default slave: answers any active transfer to an unmapped or disabled
// region with the two-cycle ERROR response (wait+ERROR, then ready+ERROR).
module ahblite_default_slave
    import ahblite_slave_mux_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       unmapped,
    output logic       HREADYOUT,
    output logic       HRESP
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       active;

    // Only NONSEQ and SEQ are real transfers; IDLE/BUSY get a zero-wait OKAY.
    assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    // Next state. ERR2 is the HREADY=1 edge, so a fresh unmapped transfer
    // may start the next error straight away (back-to-back).
    always_comb begin
        state_d = DS_IDLE;
        case (state_q)
            DS_IDLE: state_d = (HREADY && active && unmapped) ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = (active && unmapped) ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // State register; reset aborts any error in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= DS_IDLE;
        else        state_q <= state_d;
    end

    // Moore outputs, registered state only, so nothing loops back to HREADY.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DS_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite return path: registers the decoder's address-phase select into
// the data phase and muxes the owning slave's HRDATA/HREADYOUT/HRESP back to
// the master. Nothing selected means the default slave owns the data phase.
module ahblite_slave_mux
    import ahblite_slave_mux_pkg::*;
#(
    parameter bit Port0_en = 1'b1,  // RAMCODE
    parameter bit Port1_en = 1'b1,  // RAMDATA
    parameter bit Port2_en = 1'b1,  // LCD
    parameter bit Port3_en = 1'b1,  // UART
    parameter bit Port4_en = 1'b1,  // LED
    parameter bit Port5_en = 1'b1   // Buzzer
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahblite_slave_mux_if.slave  bus
);

    localparam logic [NUM_PORTS-1:0] PORT_EN =
        {Port5_en, Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

    logic [NUM_PORTS-1:0] hsel_en;
    logic [NUM_PORTS-1:0] sel_q;
    logic [NUM_PORTS-1:0] grant;
    logic                 unmapped;
    logic                 ds_hreadyout;
    logic                 ds_hresp;
    logic [HDATA_W-1:0]   hrdata_mux;
    logic                 hready_mux;
    logic                 hresp_mux;

    // Disabled ports are masked here so they look exactly like unmapped space.
    assign hsel_en  = bus.hsel & PORT_EN;
    assign unmapped = ~|hsel_en;

    // Data-phase select: advances only when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET)          sel_q <= '0;
        else if (hready_mux) sel_q <= hsel_en;
    end

    assign grant = lowest_set(sel_q);

    // Output mux, purely from the registered select; default slave when empty.
    always_comb begin
        hrdata_mux = '0;
        hready_mux = ds_hreadyout;
        hresp_mux  = ds_hresp;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant[k]) begin
                hrdata_mux = bus.slv_hrdata[k];
                hready_mux = bus.slv_hreadyout[k];
                hresp_mux  = bus.slv_hresp[k];
            end
        end
    end

    assign bus.hrdata = hrdata_mux;
    assign bus.hready = hready_mux;
    assign bus.hresp  = hresp_mux;

    ahblite_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (hready_mux),
        .HTRANS    (bus.htrans),
        .unmapped  (unmapped),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp)
    );

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: one full build and one build with the LCD
// port disabled, driven in lockstep. Each cycle's expected data-phase outputs
// are queued as the stimulus is applied and popped at the falling edge.
module tb_ahblite_slave_mux;
    import ahblite_slave_mux_pkg::*;

    localparam logic [1:0] ID = HTRANS_IDLE;
    localparam logic [1:0] BZ = HTRANS_BUSY;
    localparam logic [1:0] NS = HTRANS_NONSEQ;
    localparam logic [1:0] SQ = HTRANS_SEQ;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahblite_slave_mux_if bus_a ();
    ahblite_slave_mux_if bus_b ();

    ahblite_slave_mux dut_a (.HCLK(HCLK), .HRESET(HRESET), .bus(bus_a.slave));
    ahblite_slave_mux #(.Port2_en(1'b0)) dut_b (.HCLK(HCLK), .HRESET(HRESET), .bus(bus_b.slave));

    typedef struct {
        bit          on_b;
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Apply one cycle of stimulus just after the rising edge, to both builds.
    task automatic drive(input logic rst, input logic [1:0] tr, input logic [5:0] sl,
                         input logic [5:0] rdy, input logic [5:0] rsp);
        @(posedge HCLK);
        #1;
        HRESET = rst;
        bus_a.htrans = tr;  bus_a.hsel = sl;  bus_a.slv_hreadyout = rdy;  bus_a.slv_hresp = rsp;
        bus_b.htrans = tr;  bus_b.hsel = sl;  bus_b.slv_hreadyout = rdy;  bus_b.slv_hresp = rsp;
    endtask

    task automatic push(input bit b, input logic [31:0] d, input logic r, input logic s);
        exp_t e;
        e.on_b = b; e.rdata = d; e.ready = r; e.resp = s;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        drive(1'b1, NS, 6'b000010, 6'h3f, 6'h00);
        drive(1'b1, NS, 6'b000000, 6'h3f, 6'h00);
        push(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                drive(1'b0, ID, 6'h00, 6'h3f, 6'h00);
                push(1'b0, 32'h0, 1'b1, 1'b0);
            end
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL reset[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL reset[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL reset[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // Zero-wait mapped read, then an unmapped NONSEQ during its data phase.
    task automatic test_mapped_read();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic [1:0]  tr [5] = '{NS, NS, ID, ID, ID};
        logic [5:0]  sl [5] = '{6'b000010, 6'b000000, 6'b0, 6'b0, 6'b0};
        logic [31:0] ed [5] = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0};
        logic        er [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        es [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, tr[i], sl[i], 6'h3f, 6'h00);
            push(1'b0, ed[i], er[i], es[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL map_rd[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL map_rd[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL map_rd[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // Port 3 inserts 3 wait states while port 4 is already on the address bus.
    task automatic test_wait_states();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic [1:0]  tr [7] = '{NS, NS, NS, NS, NS, ID, ID};
        logic [5:0]  sl [7] = '{6'b001000, 6'b010000, 6'b010000, 6'b010000, 6'b010000, 6'b0, 6'b0};
        logic [5:0]  rd [7] = '{6'h3f, 6'h37, 6'h37, 6'h37, 6'h3f, 6'h3f, 6'h3f};
        logic [31:0] ed [7] = '{32'h0, 32'hA5A5_0003, 32'hA5A5_0003, 32'hA5A5_0003,
                                32'hA5A5_0003, 32'hA5A5_0004, 32'h0};
        logic        er [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, tr[i], sl[i], rd[i], 6'h00);
            push(1'b0, ed[i], er[i], 1'b0);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL wait[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL wait[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL wait[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // Overlapping selects resolve to the lowest port; its HRESP passes through.
    task automatic test_priority();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic [1:0]  tr [4] = '{NS, NS, ID, ID};
        logic [5:0]  sl [4] = '{6'b101000, 6'b110001, 6'b0, 6'b0};
        logic [5:0]  rs [4] = '{6'h00, 6'b100000, 6'b000001, 6'h00};
        logic [31:0] ed [4] = '{32'h0, 32'hA5A5_0003, 32'hA5A5_0000, 32'h0};
        logic        es [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, tr[i], sl[i], 6'h3f, rs[i]);
            push(1'b0, ed[i], 1'b1, es[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL prio[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL prio[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL prio[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // Single error, back-to-back errors, and a mapped transfer issued in ERR1/ERR2.
    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic [1:0]  tr [15] = '{NS, ID, ID, ID,
                                 NS, SQ, NS, ID, ID, ID,
                                 NS, NS, NS, ID, ID};
        logic [5:0]  sl [15] = '{6'b0, 6'b0, 6'b0, 6'b0,
                                 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0,
                                 6'b0, 6'b000010, 6'b000010, 6'b0, 6'b0};
        logic [31:0] ed [15] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'hA5A5_0001, 32'h0};
        logic        er [15] = '{1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        es [15] = '{1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, tr[i], sl[i], 6'h3f, 6'h00);
            push(1'b0, ed[i], er[i], es[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL err[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL err[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL err[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // LCD-disabled build: P2 select errors, BUSY is zero-wait OKAY, P2|P4 goes to P4.
    task automatic test_disabled_port();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic [1:0]  tr [8] = '{NS, ID, ID, BZ, ID, NS, ID, ID};
        logic [5:0]  sl [8] = '{6'b000100, 6'b0, 6'b0, 6'b0, 6'b000100, 6'b010100, 6'b0, 6'b0};
        logic [31:0] ed [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0004, 32'h0};
        logic        er [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        es [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tr[i], sl[i], 6'h3f, 6'h00);
            push(1'b1, ed[i], er[i], es[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = e.on_b ? bus_b.hrdata : bus_a.hrdata;
            gr = e.on_b ? bus_b.hready : bus_a.hready;
            gs = e.on_b ? bus_b.hresp  : bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL dis[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL dis[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL dis[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    // Reset in ERR1, in a mapped data phase, and in ERR2 with a new error pending.
    task automatic test_reset_in_error();
        exp_t e;
        logic [31:0] gd; logic gr, gs;
        logic        rs [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  tr [10] = '{NS, ID, ID, NS, ID, ID, NS, ID, NS, ID};
        logic [5:0]  sl [10] = '{6'b0, 6'b0, 6'b0, 6'b000010, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        logic [31:0] ed [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0001,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        er [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        es [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(rs[i], tr[i], sl[i], 6'h3f, 6'h00);
            push(1'b0, ed[i], er[i], es[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            gd = bus_a.hrdata; gr = bus_a.hready; gs = bus_a.hresp;
            total++; if (gd !== e.rdata) begin bad++; $display("FAIL rst_err[%0d] hrdata got %h want %h", i, gd, e.rdata); end
            total++; if (gr !== e.ready) begin bad++; $display("FAIL rst_err[%0d] hready got %b want %b", i, gr, e.ready); end
            total++; if (gs !== e.resp)  begin bad++; $display("FAIL rst_err[%0d] hresp got %b want %b", i, gs, e.resp); end
        end
    endtask

    initial begin
        HRESET = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) begin
            bus_a.slv_hrdata[k] = 32'hA5A5_0000 + 32'(k);
            bus_b.slv_hrdata[k] = 32'hA5A5_0000 + 32'(k);
        end
        bus_a.htrans = ID; bus_a.hsel = '0; bus_a.slv_hreadyout = '1; bus_a.slv_hresp = '0;
        bus_b.htrans = ID; bus_b.hsel = '0; bus_b.slv_hreadyout = '1; bus_b.slv_hresp = '0;

        test_reset();
        test_mapped_read();
        test_wait_states();
        test_priority();
        test_back_to_back();
        test_disabled_port();
        test_reset_in_error();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
